pc_sequencer: RTL and testbench

- Multi-cycle control FSM that drives the program counter's update controls: ctrl (sequential advance), isBranch and isJump.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Handshakes with instruction and data memory, and issues exactly one PC-update pulse per retired instruction.
- Sits between the instruction register/opcode decode and the PC, register file and memory strobes of the FullCPU.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode and state encodings for the multi-cycle CPU control path.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_MEM    = 4'd4;
    localparam logic [3:0] S_WB     = 4'd5;
    localparam logic [3:0] S_UPDATE = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_FAULT  = 4'd8;

    // Opcodes that pass through EXEC (J and HALT are resolved in DECODE).
    function automatic logic needs_exec(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic uses_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory ready; flags expiry on the LIMIT-th wait cycle.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    // LIMIT of zero means wait forever.
    if (LIMIT == 0) begin : g_off
        assign expired = 1'b0;
    end else begin : g_on
        assign expired = enable && (cnt == W'(LIMIT - 1));
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving PC update controls
// and register/memory strobes; one PC-update pulse per retired instruction.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_write,
    output logic             alu_src_imm,
    output logic             pc_ctrl,
    output logic             pc_is_branch,
    output logic             pc_is_jump,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [5:0] op_q;
    logic       waiting;
    logic       ready_now;
    logic       tmo;

    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    assign ready_now = (state == S_FETCH) ? imem_ready : dmem_ready;

    // Any non-waiting state clears the timer, so entry to FETCH/MEM always starts at zero.
    mem_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .enable  (waiting && !ready_now),
        .expired (tmo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready)   state_nxt = S_DECODE;
                else if (tmo)     state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (opcode == OP_J)         state_nxt = S_UPDATE;
                else if (opcode == OP_HALT) state_nxt = S_HALT;
                else if (needs_exec(opcode)) state_nxt = S_EXEC;
                else                        state_nxt = S_FAULT;
            end
            S_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) state_nxt = S_MEM;
                else if (op_q == OP_BEQ)                state_nxt = S_UPDATE;
                else                                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)   state_nxt = (op_q == OP_LW) ? S_WB : S_UPDATE;
                else if (tmo)     state_nxt = S_FAULT;
            end
            S_WB:     state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= opcode;
            if (state == S_UPDATE) instr_count <= instr_count + 1'b1;
        end
    end

    // Moore outputs from state and latched opcode; ir_load alone follows imem_ready.
    always_comb begin
        imem_req     = (state == S_FETCH);
        ir_load      = (state == S_FETCH) && imem_ready;
        dmem_rd      = (state == S_MEM) && (op_q == OP_LW);
        dmem_wr      = (state == S_MEM) && (op_q == OP_SW);
        reg_write    = (state == S_WB);
        alu_src_imm  = ((state == S_EXEC) || (state == S_MEM)) && uses_imm(op_q);
        pc_is_jump   = (state == S_UPDATE) && (op_q == OP_J);
        pc_is_branch = (state == S_UPDATE) && (op_q == OP_BEQ);
        pc_ctrl      = (state == S_UPDATE) && (op_q != OP_J) && (op_q != OP_BEQ);
        halted       = (state == S_HALT) || (state == S_FAULT);
        fault        = (state == S_FAULT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: per-instruction expected records are
// computed from the instruction timing rules and popped by a cycle monitor at each retire/stop.
module tb_pc_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int TO = 15;
    localparam int RW = 69;
    localparam logic [4:0] K_CTRL  = 5'b00001;
    localparam logic [4:0] K_BR    = 5'b00010;
    localparam logic [4:0] K_J     = 5'b00100;
    localparam logic [4:0] K_HALT  = 5'b01000;
    localparam logic [4:0] K_FAULT = 5'b11000;

    logic        clk = 1'b0;
    logic        rst, start, imem_ready, dmem_ready;
    logic [5:0]  opcode;
    logic        imem_req, ir_load, dmem_rd, dmem_wr, reg_write, alu_src_imm;
    logic        pc_ctrl, pc_is_branch, pc_is_jump, halted, fault;
    logic [15:0] instr_count;
    logic        imem_req_b, ir_load_b, dmem_rd_b, dmem_wr_b, reg_write_b, alu_src_imm_b;
    logic        pc_ctrl_b, pc_is_branch_b, pc_is_jump_b, halted_b, fault_b;
    logic [3:0]  instr_count_b;

    int total = 0;
    int bad = 0;
    int retired = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .reg_write(reg_write), .alu_src_imm(alu_src_imm), .pc_ctrl(pc_ctrl),
        .pc_is_branch(pc_is_branch), .pc_is_jump(pc_is_jump), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    pc_sequencer #(.CNT_W(4), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req_b), .ir_load(ir_load_b), .dmem_rd(dmem_rd_b), .dmem_wr(dmem_wr_b),
        .reg_write(reg_write_b), .alu_src_imm(alu_src_imm_b), .pc_ctrl(pc_ctrl_b),
        .pc_is_branch(pc_is_branch_b), .pc_is_jump(pc_is_jump_b), .halted(halted_b),
        .fault(fault_b), .instr_count(instr_count_b)
    );

    function automatic logic [RW-1:0] pack_rec(input logic [4:0] kind, input int lat, input int ireq,
                                               input int rd, input int wr, input int rw, input int imm,
                                               input logic [15:0] c16, input logic [3:0] c4);
        return {kind, 8'(lat), 8'(ireq), 8'(rd), 8'(wr), 4'(rw), 8'(imm), c16, c4};
    endfunction

    // Reference timing: fw/dw are ready-low wait cycles before the fetch/memory handshake.
    function automatic logic [RW-1:0] model(input logic [5:0] op, input int fw, input int dw, input int done);
        int base;
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = done[15:0];
        c4  = done[3:0];
        if (fw >= TO) return pack_rec(K_FAULT, TO + 1, TO, 0, 0, 0, 0, c16, c4);
        base = fw + 1;
        case (op)
            OP_RTYPE: return pack_rec(K_CTRL, base + 4, base, 0, 0, 1, 0, c16, c4);
            OP_ADDI:  return pack_rec(K_CTRL, base + 4, base, 0, 0, 1, 1, c16, c4);
            OP_BEQ:   return pack_rec(K_BR, base + 3, base, 0, 0, 0, 0, c16, c4);
            OP_J:     return pack_rec(K_J, base + 2, base, 0, 0, 0, 0, c16, c4);
            OP_HALT:  return pack_rec(K_HALT, base + 2, base, 0, 0, 0, 0, c16, c4);
            OP_LW: begin
                if (dw >= TO) return pack_rec(K_FAULT, base + 3 + TO, base, TO, 0, 0, TO + 1, c16, c4);
                return pack_rec(K_CTRL, base + dw + 5, base, dw + 1, 0, 1, dw + 2, c16, c4);
            end
            OP_SW: begin
                if (dw >= TO) return pack_rec(K_FAULT, base + 3 + TO, base, 0, TO, 0, TO + 1, c16, c4);
                return pack_rec(K_CTRL, base + dw + 4, base, 0, dw + 1, 0, dw + 2, c16, c4);
            end
            default:  return pack_rec(K_FAULT, base + 2, base, 0, 0, 0, 0, c16, c4);
        endcase
    endfunction

    function automatic bit retires(input logic [5:0] op, input int fw, input int dw);
        if (fw >= TO) return 1'b0;
        if (op == OP_LW || op == OP_SW) return dw < TO;
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit want_mem, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        while (!(want_mem ? (dmem_rd || dmem_wr) : imem_req)) begin
            step();
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL wait_%s: no strobe after %0d cycles, expected within 50",
                         want_mem ? "mem" : "fetch", n);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int dw);
        bit ok;
        exp_q.push_back(model(op, fw, dw, retired));
        if (retires(op, fw, dw)) retired++;
        wait_for(1'b0, ok);
        if (!ok) return;
        if (fw >= TO) begin
            repeat (TO + 2) step();
            return;
        end
        repeat (fw) step();
        opcode = op;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        if (op == OP_LW || op == OP_SW) begin
            wait_for(1'b1, ok);
            if (!ok) return;
            if (dw >= TO) begin
                repeat (TO + 2) step();
                return;
            end
            repeat (dw) step();
            dmem_ready = 1'b1;
            step();
            dmem_ready = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d records outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_outs"}, 32'({imem_req, ir_load, dmem_rd, dmem_wr, reg_write, alu_src_imm,
                                    pc_ctrl, pc_is_branch, pc_is_jump, halted, fault}), 32'd0);
        check({name, "_cnt"}, 32'(instr_count), 32'd0);
        check({name, "_cnt4"}, 32'(instr_count_b), 32'd0);
    endtask

    task automatic reset_dut();
        drain();
        rst = 1'b0;
        start = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode = '0;
        retired = 0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b1;
        step();
        start = 1'b1;
    endtask

    // Monitor: per-instruction activity counters, popped against the scoreboard at retire/stop.
    int cyc, n_ireq, n_rd, n_wr, n_rw, n_imm;
    bit active = 1'b0;
    bit stopped = 1'b0;
    logic [RW-1:0] act_rec, exp_rec;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            active = 1'b0;
            stopped = 1'b0;
        end else begin
            total++;
            if (ir_load !== (imem_req && imem_ready) || ir_load_b !== (imem_req_b && imem_ready)) begin
                bad++;
                $display("FAIL ir_load_rule: ir_load=%b req=%b rdy=%b", ir_load, imem_req, imem_ready);
            end
            total++;
            if ($countones({pc_ctrl, pc_is_branch, pc_is_jump}) > 1 || (fault && !halted) ||
                $countones({pc_ctrl_b, pc_is_branch_b, pc_is_jump_b}) > 1 || (fault_b && !halted_b)) begin
                bad++;
                $display("FAIL pc_onehot: pc=%b%b%b halted=%b fault=%b expected at most one pc bit",
                         pc_is_jump, pc_is_branch, pc_ctrl, halted, fault);
            end
            if (stopped) begin
                total++;
                if (!halted || imem_req || pc_ctrl || pc_is_branch || pc_is_jump) begin
                    bad++;
                    $display("FAIL sticky_stop: halted=%b imem_req=%b pc=%b%b%b expected 1,0,000",
                             halted, imem_req, pc_is_jump, pc_is_branch, pc_ctrl);
                end
            end else begin
                if (!active && imem_req) begin
                    active = 1'b1;
                    cyc = 0; n_ireq = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_imm = 0;
                end
                if (active || halted) begin
                    cyc++;
                    n_ireq += int'(imem_req);
                    n_rd   += int'(dmem_rd);
                    n_wr   += int'(dmem_wr);
                    n_rw   += int'(reg_write);
                    n_imm  += int'(alu_src_imm);
                    if (pc_ctrl || pc_is_branch || pc_is_jump || halted) begin
                        act_rec = pack_rec({fault, halted, pc_is_jump, pc_is_branch, pc_ctrl}, cyc, n_ireq,
                                           n_rd, n_wr, n_rw, n_imm, instr_count, instr_count_b);
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL retire_rec: got %h with no expected record", act_rec);
                        end else begin
                            exp_rec = exp_q.pop_front();
                            if (act_rec !== exp_rec) begin
                                bad++;
                                $display("FAIL retire_rec: got %h expected %h", act_rec, exp_rec);
                            end
                        end
                        if (halted) stopped = 1'b1;
                        active = 1'b0;
                    end
                end
            end
        end
    end

    logic [5:0] legal_ops [6];

    initial begin
        bit ok;
        int fw, dw;
        legal_ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        rst = 1'b0;
        start = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode = '0;

        // Directed mix, timeout boundaries just below the limit, then random traffic.
        reset_dut();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_ADDI, TO - 1, 0);
        run_instr(OP_LW, 0, TO - 1);
        run_instr(OP_SW, 1, 2);
        for (int i = 0; i < 40; i++) begin
            fw = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            run_instr(legal_ops[$urandom_range(0, 5)], fw, dw);
        end
        drain();

        // HALT after two ADDIs; start toggling afterwards must not restart anything.
        reset_dut();
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_HALT, 0, 0);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            step();
        end
        drain();
        check("halt_count", 32'(instr_count), 32'd2);

        reset_dut();
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b010101, 0, 0);
        drain();

        reset_dut();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_RTYPE, TO, 0);
        drain();

        reset_dut();
        run_instr(OP_SW, 0, TO);
        drain();

        // Seventeen retirements wrap the 4-bit counter back to 1.
        reset_dut();
        for (int i = 0; i < 17; i++) run_instr(OP_RTYPE, 0, 0);
        drain();
        repeat (2) step();
        check("wrap_cnt16", 32'(instr_count), 32'd17);
        check("wrap_cnt4", 32'(instr_count_b), 32'd1);

        // Asynchronous reset while a load is stalled in MEM.
        reset_dut();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        drain();
        opcode = OP_LW;
        wait_for(1'b0, ok);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        wait_for(1'b1, ok);
        step();
        check("mid_mem_rd", 32'(dmem_rd), 32'd1);
        check("mid_mem_cnt", 32'(instr_count), 32'd2);
        #2 rst = 1'b0;
        #1 check_idle("mid_mem_reset");
        start = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("post_reset_idle", 32'(imem_req), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
